// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared types and Booth opcodes for the sequential multiplier
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef logic [1:0] booth_op_t;

  localparam booth_op_t BOOTH_NOP = 2'b00;
  localparam booth_op_t BOOTH_ADD = 2'b01;
  localparam booth_op_t BOOTH_SUB = 2'b10;

  // Radix-2 recoding of the current multiplier bit pair {Q[0], q_m1}
  function automatic booth_op_t booth_decode(input logic q0, input logic q_m1);
    case ({q0, q_m1})
      2'b01:   return BOOTH_ADD;
      2'b10:   return BOOTH_SUB;
      default: return BOOTH_NOP;
    endcase
  endfunction

endpackage

// File: rtl/booth_step.sv
// rtl/booth_step.sv - one combinational radix-2 Booth add/sub and arithmetic shift
module booth_step
  import mul_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   a,
  input  logic [WIDTH-1:0] q,
  input  logic             q_m1,
  input  logic [WIDTH:0]   m,
  output logic [WIDTH:0]   a_next,
  output logic [WIDTH-1:0] q_next,
  output logic             q_m1_next
);

  logic [WIDTH:0] sum;

  // Add or subtract the multiplicand, then shift {A,Q,q_m1} right keeping A's sign
  always_comb begin
    sum = a;
    case (booth_decode(q[0], q_m1))
      BOOTH_ADD: sum = a + m;
      BOOTH_SUB: sum = a - m;
      default:   sum = a;
    endcase
    a_next    = {sum[WIDTH], sum[WIDTH:1]};
    q_next    = {sum[0], q[WIDTH-1:1]};
    q_m1_next = q[0];
  end

endmodule

// File: rtl/seq_booth_multiplier.sv
// rtl/seq_booth_multiplier.sv - sequential radix-2 Booth signed multiplier with start/done handshake
module seq_booth_multiplier
  import mul_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product_hi,
  output logic [WIDTH-1:0] product_lo
);

  state_t           state;
  logic [WIDTH:0]   a_reg;
  logic [WIDTH:0]   m_reg;
  logic [WIDTH-1:0] q_reg;
  logic             q_m1;
  logic [CNT_W-1:0] count;

  logic [WIDTH:0]   a_next;
  logic [WIDTH-1:0] q_next;
  logic             q_m1_next;

  booth_step #(.WIDTH(WIDTH)) u_step (
    .a         (a_reg),
    .q         (q_reg),
    .q_m1      (q_m1),
    .m         (m_reg),
    .a_next    (a_next),
    .q_next    (q_next),
    .q_m1_next (q_m1_next)
  );

  // Control FSM and datapath: accept in IDLE, one Booth step per RUN edge, publish on the last step
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      product_hi <= '0;
      product_lo <= '0;
      a_reg      <= '0;
      m_reg      <= '0;
      q_reg      <= '0;
      q_m1       <= 1'b0;
      count      <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            m_reg <= {multiplicand[WIDTH-1], multiplicand};
            q_reg <= multiplier;
            a_reg <= '0;
            q_m1  <= 1'b0;
            count <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          a_reg <= a_next;
          q_reg <= q_next;
          q_m1  <= q_m1_next;
          count <= count + CNT_W'(1);
          if (count == CNT_W'(WIDTH - 1)) begin
            product_hi <= a_next[WIDTH-1:0];
            product_lo <= q_next;
            busy       <= 1'b0;
            done       <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
